// File: rtl/psum_shift_acc_pkg.sv
// Shared constants and state encoding for the bit-serial shift-accumulator.
//   PSA_PREC_IN   default width of one signed tree sum
//   PSA_N_PLANES  default number of activation bit-planes per result
//   psa_state_e   controller state encoding
package psum_shift_acc_pkg;

    localparam int PSA_PREC_IN  = 10;
    localparam int PSA_N_PLANES = 8;

    typedef enum logic [1:0] {
        PSA_IDLE = 2'b00,
        PSA_ACC  = 2'b01,
        PSA_HOLD = 2'b10
    } psa_state_e;

endpackage

// File: rtl/psum_shift_acc.sv
// Bit-serial shift-accumulator sitting after the group adder tree. Takes one
// signed tree sum per activation bit-plane (MSB/sign plane first), folds
// N_PLANES planes into a full-precision signed result and offers it on a
// valid/ready port.
//
// Ports
//   CLK        clock
//   RESET_N    asynchronous active-low reset
//   start      pulse, begins a new accumulation (IDLE, or HOLD with handshake)
//   in_valid   in_psum valid this cycle
//   in_psum    signed tree sum for the current plane
//   out_valid  out_data holds a finished result
//   out_ready  consumer accepts out_data when out_valid & out_ready
//   out_data   signed accumulated result
//   busy       controller not idle
//   drop_err   sticky, a plane arrived outside ACC and was discarded
//
// state | meaning
// IDLE  | waiting for start
// ACC   | collecting planes, cnt = planes consumed so far
// HOLD  | result presented, waiting for out_ready
module psum_shift_acc
    import psum_shift_acc_pkg::*;
#(
    parameter int PREC_IN  = PSA_PREC_IN,
    parameter int N_PLANES = PSA_N_PLANES,
    parameter int PREC_OUT = PREC_IN + N_PLANES
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                start,
    input  logic                in_valid,
    input  logic [PREC_IN-1:0]  in_psum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PREC_OUT-1:0] out_data,
    output logic                busy,
    output logic                drop_err
);

    localparam int             CNT_W    = $clog2(N_PLANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PLANES - 1);

    function automatic logic signed [PREC_OUT-1:0] sext_shift_add(
        input logic signed [PREC_OUT-1:0] acc,
        input logic signed [PREC_OUT-1:0] addend
    );
        return (acc <<< 1) + addend;
    endfunction

    psa_state_e                  state_q, state_d;
    logic signed [PREC_OUT-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        out_valid_q, out_valid_d;
    logic [PREC_OUT-1:0]         out_data_q, out_data_d;
    logic                        drop_err_q, drop_err_d;

    logic signed [PREC_OUT-1:0]  psum_ext;
    logic signed [PREC_OUT-1:0]  acc_next;
    logic                        accept;
    logic                        plane_take;
    logic                        last_plane;
    logic                        restart;

    assign psum_ext   = {{(PREC_OUT-PREC_IN){in_psum[PREC_IN-1]}}, in_psum};
    assign accept     = out_valid_q & out_ready;
    assign plane_take = (state_q == PSA_ACC) & in_valid;
    assign last_plane = plane_take & (cnt_q == CNT_LAST);
    assign restart    = ((state_q == PSA_IDLE) & start) |
                        ((state_q == PSA_HOLD) & accept & start);

    // The sign plane carries weight -2^(N_PLANES-1); negating it up front lets
    // every later plane use the same shift-and-add. PREC_OUT leaves headroom
    // so negating the most negative tree sum stays exact.
    assign acc_next = (cnt_q == '0) ? -psum_ext : sext_shift_add(acc_q, psum_ext);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PSA_IDLE: if (start)      state_d = PSA_ACC;
            PSA_ACC:  if (last_plane) state_d = PSA_HOLD;
            PSA_HOLD: if (accept)     state_d = start ? PSA_ACC : PSA_IDLE;
            default:                  state_d = PSA_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (restart) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (plane_take) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= PSA_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        // Any plane outside ACC (including one coincident with start in IDLE)
        // is discarded and flagged.
        drop_err_d  = drop_err_q | (in_valid & (state_q != PSA_ACC));
        if (last_plane) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_next;
        end else if ((state_q == PSA_HOLD) && accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign drop_err  = drop_err_q;
    assign busy      = (state_q != PSA_IDLE);

endmodule

// File: tb/tb_psum_shift_acc.sv
module tb_psum_shift_acc;

    localparam int PREC_IN = 10;
    localparam int N4      = 4;
    localparam int N8      = 8;
    localparam int W4      = PREC_IN + N4;
    localparam int W8      = PREC_IN + N8;

    logic CLK = 1'b0;
    logic RESET_N;

    logic               start, in_valid, out_ready;
    logic [PREC_IN-1:0] in_psum;
    logic               out_valid, busy, drop_err;
    logic [W4-1:0]      out_data;

    logic               start8, in_valid8, out_ready8;
    logic [PREC_IN-1:0] in_psum8;
    logic               out_valid8, busy8, drop_err8;
    logic [W8-1:0]      out_data8;

    psum_shift_acc #(.PREC_IN(PREC_IN), .N_PLANES(N4)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .in_valid(in_valid),
        .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .drop_err(drop_err)
    );

    psum_shift_acc #(.PREC_IN(PREC_IN), .N_PLANES(N8)) u_dut8 (
        .CLK(CLK), .RESET_N(RESET_N), .start(start8), .in_valid(in_valid8),
        .in_psum(in_psum8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .busy(busy8), .drop_err(drop_err8)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     p[4];
        int     gap;
        int     hold;
        bit     chain;
        longint exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Weighted sum of bit-planes: plane 0 is the sign plane.
    function automatic longint model(input int q[$]);
        longint r = 0;
        int n = q.size();
        for (int i = 0; i < n; i++) begin
            longint w = longint'(1) << (n - 1 - i);
            if (i == 0) r -= longint'(q[i]) * w;
            else        r += longint'(q[i]) * w;
        end
        return r;
    endfunction

    function automatic void set_vec(input int idx, input int a, input int b,
                                    input int c, input int d, input int gap,
                                    input int hold, input bit chain, input longint exp);
        vecs[idx].p[0] = a;
        vecs[idx].p[1] = b;
        vecs[idx].p[2] = c;
        vecs[idx].p[3] = d;
        vecs[idx].gap  = gap;
        vecs[idx].hold = hold;
        vecs[idx].chain = chain;
        vecs[idx].exp  = exp;
    endfunction

    // One accumulation on the N=4 instance. Random start pulses are thrown
    // into ACC gaps and into HOLD without ready; both must be ignored.
    task automatic run4(input int q[$], input int gap, input int hold,
                        input bit do_start, input bit chain_next,
                        input longint exp, input string nm);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk({nm, "_busy"}, longint'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_psum  = PREC_IN'(q[i]);
            if (i == 3) chk({nm, "_early_valid"}, longint'(out_valid), 0);
            tick();
            in_valid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    start = 1'($urandom_range(0, 1));
                    tick();
                end
                start = 1'b0;
            end
        end
        chk({nm, "_valid"}, longint'(out_valid), 1);
        chk({nm, "_data"}, longint'($signed(out_data)), exp);
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        if (hold > 0) begin
            chk({nm, "_held_valid"}, longint'(out_valid), 1);
            chk({nm, "_held_data"}, longint'($signed(out_data)), exp);
        end
        out_ready = 1'b1;
        start     = chain_next;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        chk({nm, "_accepted"}, longint'(out_valid), 0);
        chk({nm, "_busy_after"}, longint'(busy), longint'(chain_next));
    endtask

    task automatic run8(input int q[$], input longint exp, input string nm);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid8 = 1'b1;
            in_psum8  = PREC_IN'(q[i]);
            if (i == 7) chk({nm, "_early_valid"}, longint'(out_valid8), 0);
            tick();
            in_valid8 = 1'b0;
        end
        chk({nm, "_valid"}, longint'(out_valid8), 1);
        chk({nm, "_data"}, longint'($signed(out_data8)), exp);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        chk({nm, "_accepted"}, longint'(out_valid8), 0);
        chk({nm, "_busy_after"}, longint'(busy8), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        bit chained;
        bit chain_i;

        RESET_N = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_psum = '0; out_ready = 1'b0;
        start8 = 1'b0; in_valid8 = 1'b0; in_psum8 = '0; out_ready8 = 1'b0;

        set_vec(0,    1,    0,    1,    1, 0, 0, 1'b0,   -5);
        set_vec(1,    3,   -2,    0,    7, 2, 5, 1'b1,  -25);
        set_vec(2,    3,    0,    0,    0, 0, 1, 1'b0,  -24);
        set_vec(3, -512, -512, -512, -512, 1, 0, 1'b0,  512);
        set_vec(4,  511,  511,  511,  511, 0, 2, 1'b1, -511);
        set_vec(5, -512,  511,  511,  511, 0, 0, 1'b0, 7673);
        set_vec(6,    0,    0,    0,    1, 3, 0, 1'b0,    1);
        set_vec(7,    0,    0,    0,    0, 0, 0, 1'b0,    0);

        // Reset values, then a stray plane with no start.
        tick();
        tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_drop_err", longint'(drop_err), 0);
        RESET_N = 1'b1;
        tick();
        in_valid = 1'b1;
        in_psum  = PREC_IN'(9);
        tick();
        in_valid = 1'b0;
        chk("stray_drop_err", longint'(drop_err), 1);
        chk("stray_busy", longint'(busy), 0);
        chk("stray_out_valid", longint'(out_valid), 0);

        // Directed table.
        chained = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q = {};
            for (int j = 0; j < 4; j++) q.push_back(vecs[i].p[j]);
            run4(q, vecs[i].gap, vecs[i].hold, !chained, vecs[i].chain,
                 vecs[i].exp, $sformatf("vec%0d", i));
            chained = vecs[i].chain;
        end
        chk("drop_err_sticky", longint'(drop_err), 1);

        // Abort after two planes.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_psum  = PREC_IN'(5 + i);
            tick();
        end
        in_valid = 1'b0;
        RESET_N  = 1'b0;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_drop_err", longint'(drop_err), 0);
        chk("abort_out_data", longint'(out_data), 0);
        tick();
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_no_valid%0d", i), longint'(out_valid), 0);
        end
        q = {1, 1, 1, 1};
        run4(q, 0, 0, 1'b1, 1'b0, -1, "abort_fresh");

        // Random runs against the plane-weight model.
        chained = 1'b0;
        for (int r = 0; r < 25; r++) begin
            q = {};
            for (int j = 0; j < 4; j++) q.push_back($signed($urandom_range(0, 1023)) - 512);
            chain_i = (r < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            run4(q, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 !chained, chain_i, model(q), $sformatf("rnd%0d", r));
            chained = chain_i;
        end
        chk("rnd_no_drop", longint'(drop_err), 0);

        // start and in_valid together in IDLE: start wins, plane dropped.
        start    = 1'b1;
        in_valid = 1'b1;
        in_psum  = PREC_IN'(100);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("coinc_drop_err", longint'(drop_err), 1);
        q = {-7, 2, -3, 4};
        run4(q, 0, 0, 1'b0, 1'b0, model(q), "coinc_run");

        // Eight-plane instance.
        q = {};
        for (int j = 0; j < 8; j++) q.push_back(-512);
        run8(q, 512, "n8_min");
        q = {};
        for (int j = 0; j < 8; j++) q.push_back($signed($urandom_range(0, 1023)) - 512);
        run8(q, model(q), "n8_rnd");
        chk("n8_drop_err", longint'(drop_err8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
